// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared constants, state encoding and helpers for the UDP transmit path
package udp_pkg;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [15:0] IP_FLAGS_DF   = 16'h4000;
    localparam int          HDR_BYTES     = 42;
    localparam int          HDR_WORDS     = 10;

    typedef enum logic [2:0] {IDLE, CALC, HDR, PAY, TAIL, DROP} tx_state_t;

    // Byte count of a beat whose tkeep is contiguous from bit 0.
    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        case (keep)
            4'hF:    return 3'd4;
            4'h7:    return 3'd3;
            4'h3:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction
endpackage

// File: rtl/ip_hdr_checksum.sv
// rtl/ip_hdr_checksum.sv - IPv4 header checksum from a constant partial sum plus tot_len and ip_id
module ip_hdr_checksum
    import udp_pkg::*;
#(
    parameter logic [31:0] SRC_IP = {8'd192, 8'd168, 8'd18, 8'd10},
    parameter logic [31:0] DST_IP = {8'd192, 8'd168, 8'd18, 8'd1},
    parameter logic [7:0]  TTL    = 8'd64
) (
    input  logic        clk_i,
    input  logic        s_rst_i,
    input  logic        load_i,
    input  logic [15:0] tot_len_i,
    input  logic [15:0] ip_id_i,
    output logic [15:0] csum_o
);
    localparam logic [31:0] PARTIAL = {16'h0, IP_VER_IHL, 8'h00} + {16'h0, IP_FLAGS_DF}
                                    + {16'h0, TTL, IP_PROTO_UDP}
                                    + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
                                    + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};

    logic [31:0] sum;
    logic [31:0] fold1;
    logic [15:0] fold2;

    assign sum   = PARTIAL + {16'h0, tot_len_i} + {16'h0, ip_id_i};
    assign fold1 = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    assign fold2 = fold1[15:0] + fold1[31:16];

    // Held between loads so the header word can read it any time during HDR.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            csum_o <= '0;
        end else if (load_i) begin
            csum_o <= ~fold2;
        end
    end
endmodule

// File: rtl/udp_tx_framer.sv
// rtl/udp_tx_framer.sv - wraps a payload stream in Ethernet/IPv4/UDP headers toward the MAC
module udp_tx_framer
    import udp_pkg::*;
#(
    parameter int          STREAM_DATA_WIDTH = 32,
    parameter logic [47:0] SRC_MAC           = 48'h00350a000201,
    parameter logic [47:0] DST_MAC           = 48'hffffffffffff,
    parameter logic [31:0] SRC_IP            = {8'd192, 8'd168, 8'd18, 8'd10},
    parameter logic [31:0] DST_IP            = {8'd192, 8'd168, 8'd18, 8'd1},
    parameter logic [15:0] SRC_PORT          = 16'd8080,
    parameter logic [15:0] DST_PORT          = 16'd8080,
    parameter logic [7:0]  TTL               = 8'd64,
    parameter int          PAYLOAD_MAX_SIZE  = 1472,
    parameter int          LEN_WIDTH         = 11
) (
    input  logic                           clk_i,
    input  logic                           s_rst_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [LEN_WIDTH-1:0]           cmd_len_i,
    input  logic [STREAM_DATA_WIDTH-1:0]   s_axis_tdata_i,
    input  logic [STREAM_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
    input  logic                           s_axis_tvalid_i,
    input  logic                           s_axis_tlast_i,
    output logic                           s_axis_tready_o,
    output logic [STREAM_DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic [STREAM_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
    output logic                           m_axis_tvalid_o,
    output logic                           m_axis_tlast_o,
    input  logic                           m_axis_tready_i,
    output logic                           err_len_o
);
    localparam int HDR_BITS = 8 * (HDR_BYTES - 2);

    tx_state_t            state, next_state;
    logic                 cmd_ready_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [3:0]           hdr_idx, hdr_sel, tail_keep;
    logic [15:0]          carry, ip_id, cur_id, byte_cnt, csum;
    logic                 out_free, cmd_fire, s_fire, len_bad;
    logic [2:0]           in_bytes;
    logic [15:0]          len16, tot_len, udp_len, cnt_next;
    logic [HDR_BITS-1:0]  hdr;
    logic [31:0]          hdr_top, hdr_word;

    assign out_free = !m_axis_tvalid_o || m_axis_tready_i;
    assign cmd_fire = cmd_valid_i && cmd_ready_q;
    assign s_fire   = s_axis_tvalid_i && s_axis_tready_o;
    assign len_bad  = (cmd_len_i == '0) || (cmd_len_i > LEN_WIDTH'(PAYLOAD_MAX_SIZE));
    assign in_bytes = s_axis_tlast_i ? keep_bytes(s_axis_tkeep_i) : 3'd4;
    assign len16    = {{(16-LEN_WIDTH){1'b0}}, len_q};
    assign tot_len  = len16 + 16'd28;
    assign udp_len  = len16 + 16'd8;
    assign cnt_next = byte_cnt + {13'h0, in_bytes};

    ip_hdr_checksum #(.SRC_IP(SRC_IP), .DST_IP(DST_IP), .TTL(TTL)) u_csum (
        .clk_i     (clk_i),
        .s_rst_i   (s_rst_i),
        .load_i    (state == CALC),
        .tot_len_i (tot_len),
        .ip_id_i   (ip_id),
        .csum_o    (csum)
    );

    // Bytes 0..39 in wire order, first byte in the top bits; bytes 40..41 (UDP checksum) seed the carry.
    assign hdr = {DST_MAC, SRC_MAC, ETH_TYPE_IPV4, IP_VER_IHL, 8'h00, tot_len, cur_id,
                  IP_FLAGS_DF, TTL, IP_PROTO_UDP, csum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len};
    assign hdr_sel  = (state == CALC) ? 4'd0 : hdr_idx;
    assign hdr_top  = hdr[(HDR_BITS - 1) - 32 * int'(hdr_sel) -: 32];
    assign hdr_word = {hdr_top[7:0], hdr_top[15:8], hdr_top[23:16], hdr_top[31:24]};

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_fire) next_state = len_bad ? DROP : CALC;
            CALC:    next_state = HDR;
            HDR:     if (out_free && hdr_idx == 4'(HDR_WORDS - 1)) next_state = PAY;
            PAY:     if (s_fire && s_axis_tlast_i) next_state = (in_bytes > 3'd2) ? TAIL : IDLE;
            TAIL:    if (out_free) next_state = IDLE;
            DROP:    if (s_axis_tvalid_i && s_axis_tlast_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o     = cmd_ready_q;
        s_axis_tready_o = 1'b0;
        case (state)
            PAY:     s_axis_tready_o = out_free;
            DROP:    s_axis_tready_o = 1'b1;
            default: s_axis_tready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            cmd_ready_q     <= 1'b0;
            len_q           <= '0;
            hdr_idx         <= '0;
            tail_keep       <= '0;
            carry           <= '0;
            ip_id           <= '0;
            cur_id          <= '0;
            byte_cnt        <= '0;
            m_axis_tdata_o  <= '0;
            m_axis_tkeep_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            m_axis_tlast_o  <= 1'b0;
            err_len_o       <= 1'b0;
        end else begin
            cmd_ready_q <= (next_state == IDLE);
            err_len_o   <= 1'b0;
            if (m_axis_tready_i) m_axis_tvalid_o <= 1'b0;
            case (state)
                IDLE: if (cmd_fire) begin
                    len_q     <= cmd_len_i;
                    err_len_o <= len_bad;
                end
                // Word 0 is pure DST_MAC, so it goes out here to meet the two-cycle latency.
                CALC: begin
                    cur_id   <= ip_id;
                    ip_id    <= ip_id + 16'd1;
                    carry    <= '0;
                    byte_cnt <= '0;
                    hdr_idx  <= 4'd0;
                    if (out_free) begin
                        m_axis_tdata_o  <= hdr_word;
                        m_axis_tkeep_o  <= 4'hF;
                        m_axis_tlast_o  <= 1'b0;
                        m_axis_tvalid_o <= 1'b1;
                        hdr_idx         <= 4'd1;
                    end
                end
                HDR: if (out_free) begin
                    m_axis_tdata_o  <= hdr_word;
                    m_axis_tkeep_o  <= 4'hF;
                    m_axis_tlast_o  <= 1'b0;
                    m_axis_tvalid_o <= 1'b1;
                    hdr_idx         <= hdr_idx + 4'd1;
                end
                PAY: if (s_fire) begin
                    m_axis_tdata_o  <= {s_axis_tdata_i[15:0], carry};
                    m_axis_tkeep_o  <= 4'hF;
                    m_axis_tlast_o  <= 1'b0;
                    m_axis_tvalid_o <= 1'b1;
                    carry           <= s_axis_tdata_i[31:16];
                    byte_cnt        <= cnt_next;
                    if (s_axis_tlast_i) begin
                        err_len_o <= (cnt_next != len16);
                        if (in_bytes <= 3'd2) begin
                            m_axis_tlast_o <= 1'b1;
                            m_axis_tkeep_o <= (in_bytes == 3'd1) ? 4'h7 : 4'hF;
                        end else begin
                            tail_keep <= (in_bytes == 3'd3) ? 4'h1 : 4'h3;
                        end
                    end
                end
                TAIL: if (out_free) begin
                    m_axis_tdata_o  <= {16'h0, carry};
                    m_axis_tkeep_o  <= tail_keep;
                    m_axis_tlast_o  <= 1'b1;
                    m_axis_tvalid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_framer.sv
// tb/tb_udp_tx_framer.sv - scoreboard bench for udp_tx_framer
module tb_udp_tx_framer;
    logic        clk = 1'b0;
    logic        s_rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [10:0] cmd_len_i = '0;
    logic [31:0] s_axis_tdata_i = '0;
    logic [3:0]  s_axis_tkeep_i = '0;
    logic        s_axis_tvalid_i = 1'b0;
    logic        s_axis_tlast_i = 1'b0;
    logic        s_axis_tready_o;
    logic [31:0] m_axis_tdata_o;
    logic [3:0]  m_axis_tkeep_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tlast_o;
    logic        m_axis_tready_i = 1'b1;
    logic        err_len_o;

    udp_tx_framer dut (
        .clk_i           (clk),
        .s_rst_i         (s_rst_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_len_i       (cmd_len_i),
        .s_axis_tdata_i  (s_axis_tdata_i),
        .s_axis_tkeep_i  (s_axis_tkeep_i),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tlast_i  (s_axis_tlast_i),
        .s_axis_tready_o (s_axis_tready_o),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tkeep_o  (m_axis_tkeep_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tlast_o  (m_axis_tlast_o),
        .m_axis_tready_i (m_axis_tready_i),
        .err_len_o       (err_len_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    beat_t       exp_b;
    logic [31:0] mask;
    byte unsigned pay[];
    int          n_checks = 0;
    int          n_errors = 0;
    int          err_pulses = 0;
    logic [15:0] model_id = '0;
    bit          rnd_ready = 1'b0;
    bit          rnd_gaps = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_axis_tready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (err_len_o) err_pulses++;
        if (!s_rst_i && m_axis_tvalid_o && m_axis_tready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                exp_b = sb.pop_front();
                for (int j = 0; j < 4; j++) mask[8*j +: 8] = {8{exp_b.keep[j]}};
                check("tdata", m_axis_tdata_o & mask, exp_b.data & mask);
                check("tkeep", 32'(m_axis_tkeep_o), 32'(exp_b.keep));
                check("tlast", 32'(m_axis_tlast_o), 32'(exp_b.last));
            end
        end
    end

    task automatic fill_payload(input int n);
        pay = new[n];
        foreach (pay[i]) pay[i] = 8'($urandom);
    endtask

    // Reference frame: header from len (checksum recomputed here), then the n bytes actually sent.
    task automatic push_frame(input int len, input int n);
        logic [335:0] hv;
        logic [15:0]  tot, udp;
        int           sum, total;
        tot = 16'(28 + len);
        udp = 16'(8 + len);
        hv = {48'hffffffffffff, 48'h00350a000201, 16'h0800, 16'h4500, tot, model_id, 16'h4000,
              8'd64, 8'h11, 16'h0000, 8'd192, 8'd168, 8'd18, 8'd10, 8'd192, 8'd168, 8'd18, 8'd1,
              16'd8080, 16'd8080, udp, 16'h0000};
        sum = 0;
        for (int k = 0; k < 10; k++) sum += int'(hv[335 - 8 * (14 + 2 * k) -: 16]);
        while ((sum >> 16) != 0) sum = (sum & 32'hffff) + (sum >> 16);
        hv[335 - 8 * 24 -: 16] = ~sum[15:0];
        total = 42 + n;
        for (int i = 0; i < total; i += 4) begin
            beat_t b;
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < total) begin
                    b.data[8*j +: 8] = (i + j < 42) ? hv[335 - 8 * (i + j) -: 8] : pay[i + j - 42];
                    b.keep[j] = 1'b1;
                end
            end
            b.last = (i + 4 >= total);
            sb.push_back(b);
        end
        model_id = model_id + 16'd1;
    endtask

    task automatic send_cmd(input int len);
        int k;
        cmd_valid_i = 1'b1;
        cmd_len_i = len[10:0];
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (cmd_ready_o) break;
        end
        if (k == 2000) check("cmd_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic send_payload(input int n, input int stop_after);
        int beats, lim, nb, k;
        beats = (n + 3) / 4;
        lim = (stop_after > 0) ? stop_after : beats;
        for (int b = 0; b < lim; b++) begin
            if (rnd_gaps) begin
                s_axis_tvalid_i = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            nb = (n - 4 * b >= 4) ? 4 : n - 4 * b;
            for (int j = 0; j < 4; j++) s_axis_tdata_i[8*j +: 8] = (4 * b + j < n) ? pay[4 * b + j] : 8'h00;
            s_axis_tkeep_i = 4'((1 << nb) - 1);
            s_axis_tlast_i = (b == beats - 1);
            s_axis_tvalid_i = 1'b1;
            for (k = 0; k < 2000; k++) begin
                @(negedge clk);
                if (s_axis_tready_o) break;
            end
            if (k == 2000) check("s_tready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
        s_axis_tvalid_i = 1'b0;
        s_axis_tlast_i = 1'b0;
    endtask

    task automatic run_frame(input int len, input int n, input bit accepted);
        fill_payload(n);
        if (accepted) push_frame(len, n);
        send_cmd(len);
        send_payload(n, 0);
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 20000; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        model_id = '0;
        s_rst_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd0);
        check({tag, "_s_tready"}, 32'(s_axis_tready_o), 32'd0);
        check({tag, "_m_tvalid"}, 32'(m_axis_tvalid_o), 32'd0);
        check({tag, "_m_tlast"}, 32'(m_axis_tlast_o), 32'd0);
        check({tag, "_m_tkeep"}, 32'(m_axis_tkeep_o), 32'd0);
        check({tag, "_m_tdata"}, m_axis_tdata_o, 32'd0);
        check({tag, "_err_len"}, 32'(err_len_o), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        s_rst_i = 1'b0;

        // 18 bytes in 5 beats, plus command-to-first-beat latency
        fill_payload(18);
        push_frame(18, 18);
        send_cmd(18);
        @(negedge clk);
        check("lat_calc_tvalid", 32'(m_axis_tvalid_o), 32'd0);
        @(negedge clk);
        check("lat_first_tvalid", 32'(m_axis_tvalid_o), 32'd1);
        @(posedge clk);
        #1;
        send_payload(18, 0);
        wait_drain();

        run_frame(1, 1, 1'b1);
        wait_drain();
        run_frame(3, 3, 1'b1);
        wait_drain();
        run_frame(1472, 1472, 1'b1);
        wait_drain();

        e0 = err_pulses;
        run_frame(0, 6, 1'b0);
        run_frame(1473, 9, 1'b0);
        wait_drain();
        check("err_drop_pulses", 32'(err_pulses - e0), 32'd2);
        fill_payload(8);
        push_frame(10, 8);
        send_cmd(10);
        send_payload(8, 0);
        wait_drain();
        check("err_short_pulses", 32'(err_pulses - e0), 32'd3);

        // reset in the middle of PAY, then a clean frame with ip_id back at 0
        fill_payload(40);
        push_frame(40, 40);
        send_cmd(40);
        send_payload(40, 3);
        s_rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midreset");
        sb.delete();
        model_id = '0;
        @(posedge clk);
        #1;
        s_rst_i = 1'b0;
        run_frame(20, 20, 1'b1);
        wait_drain();

        do_reset();
        rnd_ready = 1'b1;
        rnd_gaps = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int len;
            len = $urandom_range(1, 128);
            run_frame(len, len, 1'b1);
        end
        wait_drain();
        check("random_ip_id_end", 32'(model_id), 32'd200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
